// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state, entry types and constants for the fetch stage
package fetch_pkg;
  typedef enum logic [2:0] {FETCH, WAIT, DRAIN, HALT_PEND, HALT} fetch_state_t;
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
  localparam logic [31:0] HALT_INSTR = 32'h0;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: {pc, instr} queue taking up to two pushes per cycle, with pop and flush
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [1:0]   push_n,
  input  fetch_entry_t d0,
  input  fetch_entry_t d1,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic         empty,
  output logic [AW:0]  free
);
  logic [AW:0] wp, rp, wp1;
  fetch_entry_t mem [DEPTH];
  assign wp1 = wp + 1'b1;
  assign empty = wp == rp;
  assign free = (AW+1)'(DEPTH) - (wp - rp);
  assign head = mem[rp[AW-1:0]];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= flush ? '0 : wp + (AW+1)'(push_n);
      rp <= flush ? '0 : rp + (AW+1)'(pop && !empty);
    end
  always_ff @(posedge clk) begin
    if (push_n != 2'd0) mem[wp[AW-1:0]] <= d0;
    if (push_n == 2'd2) mem[wp1[AW-1:0]] <= d1;
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: fetches 64-bit words, splits them into instructions and feeds the decoder
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [63:0] ENTRY_PC = 64'h0,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        bus_req,
  output logic [63:0] bus_addr,
  input  logic        bus_ack,
  input  logic        bus_resp_valid,
  input  logic [63:0] bus_resp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [63:0] out_pc,
  input  logic        out_ready,
  output logic        halted
);
  localparam int AW = $clog2(DEPTH);
  fetch_state_t state, nxt;
  fetch_entry_t head, d0, d1;
  logic [63:0] fetch_pc, base;
  logic [AW:0] free;
  logic [1:0] push_n;
  logic hold, empty, flush, pop, acc, resp, skip, lo_zero, hi_zero, stop;
  assign base = fetch_pc & ~64'h7;
  assign skip = fetch_pc[2];
  assign flush = redirect_valid && state != HALT;
  assign bus_req = state == FETCH && !hold && free >= (AW+1)'(2);
  assign bus_addr = bus_req ? base : '0;
  assign acc = bus_req && bus_ack;
  assign resp = state == WAIT && bus_resp_valid && !flush;
  assign lo_zero = bus_resp_data[31:0] == HALT_INSTR;
  assign hi_zero = bus_resp_data[63:32] == HALT_INSTR;
  assign stop = hi_zero || (!skip && lo_zero);
  assign push_n = !resp ? 2'd0 : (skip || lo_zero) ? 2'd1 : 2'd2;
  assign d0 = skip ? {base + 64'd4, bus_resp_data[63:32]} : {base, bus_resp_data[31:0]};
  assign d1 = {base + 64'd4, bus_resp_data[63:32]};
  assign out_valid = !empty && state != HALT;
  assign pop = out_valid && out_ready;
  assign out_instr = out_valid ? head.instr : '0;
  assign out_pc = out_valid ? head.pc : '0;
  assign halted = state == HALT;
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .reset_n(reset_n), .push_n(push_n), .d0(d0), .d1(d1),
    .pop(pop), .flush(flush), .head(head), .empty(empty), .free(free)
  );
  always_comb begin
    nxt = state;
    case (state)
      FETCH:     nxt = acc ? (flush ? DRAIN : WAIT) : FETCH;
      WAIT:      nxt = flush ? (bus_resp_valid ? FETCH : DRAIN) : resp ? (stop ? HALT_PEND : FETCH) : WAIT;
      DRAIN:     nxt = bus_resp_valid ? FETCH : DRAIN;
      HALT_PEND: nxt = flush ? FETCH : (pop && head.instr == HALT_INSTR) ? HALT : HALT_PEND;
      default:   nxt = HALT;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= FETCH;
      fetch_pc <= ENTRY_PC & ~64'h3;
      hold <= 1'b1;
    end else begin
      state <= nxt;
      hold <= flush;
      fetch_pc <= flush ? redirect_pc & ~64'h3 : resp ? base + 64'd8 : fetch_pc;
    end
endmodule
